gp_cmd_exec_fsm: RTL and testbench

- Execution engine of the gp_engine. Sits directly downstream of the command buffer.
- Fetches 3-word commands from the buffer over its FSM read port (cmd_rd_en/cmd_addr -> cmd_rd_valid/cmd_out).
- Decodes each command and executes it as single-beat transactions on the engine's bus-master request interface.
- Reports busy/done/error to the engine control registers.

---
 rtl/gp_cmd_exec_fsm_if.sv | 32 +++
 rtl/gp_cmd_exec_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_gp_cmd_exec_fsm.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gp_cmd_exec_fsm_if.sv
// Command-buffer read port and single-beat bus-master request channel of the gp_engine executor.
// Latency: none, this is wiring only.
// Backpressure: requests hold while mst_i_ready is low; buffer reads are not backpressured.
interface gp_cmd_exec_fsm_if #(
    parameter int CMD_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_rd_en;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_rd_valid;
    logic [CMD_WIDTH-1:0]  cmd_out;
    logic                  mst_o_valid;
    logic                  mst_o_rd0_wr1;
    logic [ADDR_WIDTH-1:0] mst_o_addr;
    logic [DATA_WIDTH-1:0] mst_o_wr_data;
    logic                  mst_i_ready;
    logic                  mst_i_rd_valid;
    logic [DATA_WIDTH-1:0] mst_i_rd_data;

    // Executor side: issues buffer reads and bus requests.
    modport master (
        output cmd_rd_en, cmd_addr, mst_o_valid, mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data,
        input  cmd_rd_valid, cmd_out, mst_i_ready, mst_i_rd_valid, mst_i_rd_data
    );

    // Buffer / bus side: answers reads and accepts requests.
    modport slave (
        input  cmd_rd_en, cmd_addr, mst_o_valid, mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data,
        output cmd_rd_valid, cmd_out, mst_i_ready, mst_i_rd_valid, mst_i_rd_data
    );
endinterface

// File: rtl/gp_cmd_exec_fsm.sv
// Fetches 3-word commands from the command buffer and runs them as single-beat bus transactions.
// Latency: 7 cycles to fetch a command, then 1 decode cycle plus bus wait; done/error one cycle after the last command.
// Backpressure: requests stay valid and stable until mst_i_ready; POLL retry bounded only with GPE_POLL_TIMEOUT_EN.
module gp_cmd_exec_fsm #(
    parameter int CMD_WIDTH  = 32,
    parameter int CMD_DEPTH  = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TMO_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] start_ptr,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    gp_cmd_exec_fsm_if.master bus
);
    // One spare bit so the pointer can express "one past the last word" for the overflow check.
    localparam int PTR_W = ($clog2(CMD_DEPTH) >= 8) ? $clog2(CMD_DEPTH) + 1 : 9;
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(CMD_DEPTH);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_POLL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXEC, S_WAIT_RD, S_DONE, S_ERR
    } state_t;

    state_t                state;
    logic [PTR_W-1:0]      ptr;
    logic [1:0]            widx;
    logic [CMD_WIDTH-1:0]  w0;
    logic                  abort_q;
    logic [1:0]            err_pend;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  mst_vld_q;
    logic                  mst_wr_q;
    // W1 and W2 are latched straight into the request registers; W2 doubles as the poll compare value.
    logic [ADDR_WIDTH-1:0] mst_addr_q;
    logic [DATA_WIDTH-1:0] mst_dat_q;

`ifdef GPE_POLL_TIMEOUT_EN
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = {{(TMO_WIDTH-1){1'b1}}, 1'b0};
    logic [TMO_WIDTH-1:0] tmo_cnt;
`else
    // Narrower timeout counters are not supported; the width is only used when the timeout is built in.
    if (TMO_WIDTH < 2) begin : g_tmo_width_unsupported
    end
`endif

    logic [PTR_W-1:0]      ptr_inc;
    logic [1:0]            op;
    logic                  last;
    logic                  abort_any;
    logic [DATA_WIDTH-1:0] poll_mask;
    logic                  poll_hit;

    assign ptr_inc   = ptr + 1'b1;
    assign op        = w0[1:0];
    assign last      = w0[2];
    assign abort_any = abort_q | abort;
    assign poll_mask = DATA_WIDTH'({w0[31:16], 16'hFFFF});
    assign poll_hit  = ((bus.mst_i_rd_data ^ mst_dat_q) & poll_mask) == '0;

    assign bus.cmd_rd_en     = rd_en_q;
    assign bus.cmd_addr      = rd_addr_q;
    assign bus.mst_o_valid   = mst_vld_q;
    assign bus.mst_o_rd0_wr1 = mst_wr_q;
    assign bus.mst_o_addr    = mst_addr_q;
    assign bus.mst_o_wr_data = mst_dat_q;

    // A finished command either ends the run (last word or pending abort) or fetches the next one.
    function automatic state_t after_cmd(input logic lst, input logic ab);
        return (lst || ab) ? S_DONE : S_FETCH;
    endfunction

    // Command fetch / execute state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            widx       <= '0;
            w0         <= '0;
            abort_q    <= 1'b0;
            err_pend   <= 2'b00;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            mst_vld_q  <= 1'b0;
            mst_wr_q   <= 1'b0;
            mst_addr_q <= '0;
            mst_dat_q  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'b00;
`ifdef GPE_POLL_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (abort && state != S_IDLE)
                abort_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    // An abort arriving together with start is dropped here.
                    abort_q <= 1'b0;
                    if (start) begin
                        ptr      <= PTR_W'(start_ptr);
                        widx     <= '0;
                        busy     <= 1'b1;
                        err_code <= 2'b00;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (ptr >= PTR_END) begin
                        err_pend <= 2'b10;
                        state    <= S_ERR;
                    end else begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= ADDR_WIDTH'(ptr);
                        state     <= S_FETCH_WAIT;
                    end
                end
                S_FETCH_WAIT: begin
                    rd_en_q <= 1'b0;
                    // Data can only belong to our request once the request cycle is over.
                    if (!rd_en_q && bus.cmd_rd_valid) begin
                        ptr <= ptr_inc;
                        case (widx)
                            2'd0:    w0         <= bus.cmd_out;
                            2'd1:    mst_addr_q <= ADDR_WIDTH'(bus.cmd_out);
                            default: mst_dat_q  <= DATA_WIDTH'(bus.cmd_out);
                        endcase
                        if (widx == 2'd2) begin
                            widx  <= '0;
                            state <= S_DECODE;
                        end else if (ptr_inc >= PTR_END) begin
                            err_pend <= 2'b10;
                            state    <= S_ERR;
                        end else begin
                            widx      <= widx + 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= ADDR_WIDTH'(ptr_inc);
                        end
                    end
                end
                S_DECODE: begin
                    if (w0[15:3] != '0) begin
                        err_pend <= 2'b01;
                        state    <= S_ERR;
                    end else if (op == OP_NOP) begin
                        state <= after_cmd(last, abort_any);
                    end else begin
                        mst_vld_q <= 1'b1;
                        mst_wr_q  <= (op == OP_WRITE);
                        state     <= S_EXEC;
`ifdef GPE_POLL_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                S_EXEC: begin
                    // Abort is not looked at here: a raised request is always carried to its handshake.
                    if (bus.mst_i_ready) begin
                        mst_vld_q <= 1'b0;
                        state     <= (op == OP_WRITE) ? after_cmd(last, abort_any) : S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    if (op == OP_POLL && abort_any) begin
                        state <= S_DONE;
                    end else if (bus.mst_i_rd_valid) begin
                        if (op == OP_READ || poll_hit) begin
                            state <= after_cmd(last, abort_any);
                        end else begin
`ifdef GPE_POLL_TIMEOUT_EN
                            tmo_cnt <= tmo_cnt + 1'b1;
                            if (tmo_cnt == TMO_LAST) begin
                                err_pend <= 2'b11;
                                state    <= S_ERR;
                            end else begin
                                mst_vld_q <= 1'b1;
                                state     <= S_EXEC;
                            end
`else
                            mst_vld_q <= 1'b1;
                            state     <= S_EXEC;
`endif
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    err_code <= err_pend;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gp_cmd_exec_fsm.sv
// Directed bench for gp_cmd_exec_fsm: behavioural command buffer and bus target with logging.
// Latency: not applicable.
// Backpressure: bus target inserts a programmable number of ready-low cycles per request.
module tb_gp_cmd_exec_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_ptr = 8'd0;
    logic       abort = 1'b0;
    logic       busy, done, error;
    logic [1:0] err_code;

    gp_cmd_exec_fsm_if #(.CMD_WIDTH(32), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    gp_cmd_exec_fsm #(.CMD_WIDTH(32), .CMD_DEPTH(256), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TMO_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_ptr (start_ptr),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] dat;
        logic [7:0]  wait_cyc;
    } tx_t;

    // Stimulus-owned model configuration.
    logic [31:0] mem [0:255];
    logic [31:0] rd_pat [0:3];
    int          rd_pat_len = 0;
    int          rd_base = 0;
    int          ready_delay = 0;
    bit          hold_ready = 1'b0;

    // Model-owned logs.
    int          fetch_q [$];
    tx_t         tx_q [$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          rd_total = 0;
    int          stable_err = 0;
    int          vcnt;
    logic        prev_hold;
    logic [64:0] prev_req;

    int n_chk = 0;
    int n_pass = 0;

    assign bus.mst_i_ready = bus.mst_o_valid && !hold_ready && (vcnt >= ready_delay);

    // Command buffer: one-cycle read latency, logs every requested index.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cmd_rd_valid <= 1'b0;
            bus.cmd_out      <= '0;
        end else begin
            bus.cmd_rd_valid <= bus.cmd_rd_en;
            bus.cmd_out      <= mem[bus.cmd_addr[7:0]];
            if (bus.cmd_rd_en)
                fetch_q.push_back(int'(bus.cmd_addr));
        end
    end

    // Bus target: accepts after ready_delay cycles, answers reads next cycle, checks request stability.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mst_i_rd_valid <= 1'b0;
            bus.mst_i_rd_data  <= '0;
            vcnt               <= 0;
            prev_hold          <= 1'b0;
            prev_req           <= '0;
        end else begin
            bus.mst_i_rd_valid <= 1'b0;
            if (prev_hold && {bus.mst_o_rd0_wr1, bus.mst_o_addr, bus.mst_o_wr_data} != prev_req)
                stable_err <= stable_err + 1;
            if (bus.mst_o_valid && bus.mst_i_ready) begin
                tx_q.push_back('{wr: bus.mst_o_rd0_wr1, addr: bus.mst_o_addr,
                                 dat: bus.mst_o_wr_data, wait_cyc: 8'(vcnt)});
                vcnt <= 0;
                if (!bus.mst_o_rd0_wr1) begin
                    bus.mst_i_rd_valid <= 1'b1;
                    bus.mst_i_rd_data  <= (rd_total - rd_base < rd_pat_len) ? rd_pat[rd_total - rd_base] : 32'h0;
                    rd_total           <= rd_total + 1;
                end
            end else if (bus.mst_o_valid) begin
                vcnt <= vcnt + 1;
            end
            prev_hold <= bus.mst_o_valid && !bus.mst_i_ready;
            prev_req  <= {bus.mst_o_rd0_wr1, bus.mst_o_addr, bus.mst_o_wr_data};
            if (done)  done_cnt <= done_cnt + 1;
            if (error) err_cnt  <= err_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_fin(input int d0, input int e0, input int budget, input string tag);
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0 || err_cnt != e0) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 64'(fin), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [7:0] sp, input logic ab);
        @(negedge clk);
        start_ptr = sp;
        start     = 1'b1;
        abort     = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    int d0, e0, f0, t0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) rd_pat[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_rd_en", 64'(bus.cmd_rd_en), 64'd0);
        chk("rst_mst_valid", 64'(bus.mst_o_valid), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single last WRITE with three ready-low cycles.
        mem[0] = 32'h0000_0005; mem[1] = 32'h1000_0010; mem[2] = 32'hDEAD_BEEF;
        ready_delay = 3;
        d0 = done_cnt; e0 = err_cnt; f0 = fetch_q.size(); t0 = tx_q.size();
        pulse_start(8'd0, 1'b0);
        chk("t1_busy_mid", 64'(busy), 64'd1);
        wait_fin(d0, e0, 200, "t1_finish");
        chk("t1_fetch_n", 64'(fetch_q.size() - f0), 64'd3);
        chk("t1_tx_n", 64'(tx_q.size() - t0), 64'd1);
        chk("t1_tx_wr", 64'(tx_q[t0].wr), 64'd1);
        chk("t1_tx_addr", 64'(tx_q[t0].addr), 64'h1000_0010);
        chk("t1_tx_data", 64'(tx_q[t0].dat), 64'hDEAD_BEEF);
        chk("t1_ready_low", 64'(tx_q[t0].wait_cyc), 64'd3);
        chk("t1_stable", 64'(stable_err), 64'd0);
        chk("t1_done", 64'(done_cnt - d0), 64'd1);
        chk("t1_no_err", 64'(err_cnt - e0), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);
        ready_delay = 0;

        // READ (not last) then WRITE (last) from index 10.
        mem[10] = 32'h0000_0002; mem[11] = 32'h2000_0000; mem[12] = 32'h0;
        mem[13] = 32'h0000_0005; mem[14] = 32'h2000_0004; mem[15] = 32'h1234_5678;
        d0 = done_cnt; e0 = err_cnt; f0 = fetch_q.size(); t0 = tx_q.size();
        pulse_start(8'd10, 1'b0);
        wait_fin(d0, e0, 300, "t2_finish");
        chk("t2_fetch_n", 64'(fetch_q.size() - f0), 64'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t2_fetch_addr%0d", i), 64'(fetch_q[f0 + i]), 64'(10 + i));
        chk("t2_tx_n", 64'(tx_q.size() - t0), 64'd2);
        chk("t2_tx0_wr", 64'(tx_q[t0].wr), 64'd0);
        chk("t2_tx0_addr", 64'(tx_q[t0].addr), 64'h2000_0000);
        chk("t2_tx1_wr", 64'(tx_q[t0 + 1].wr), 64'd1);
        chk("t2_tx1_addr", 64'(tx_q[t0 + 1].addr), 64'h2000_0004);
        chk("t2_tx1_data", 64'(tx_q[t0 + 1].dat), 64'h1234_5678);
        chk("t2_done", 64'(done_cnt - d0), 64'd1);

        // POLL mask 0x0001 value 1; third read differs only in masked-off bits.
        mem[20] = 32'h0001_0007; mem[21] = 32'h3000_0000; mem[22] = 32'h0000_0001;
        rd_pat[0] = 32'h0; rd_pat[1] = 32'h0; rd_pat[2] = 32'hFFFE_0001; rd_pat_len = 3;
        rd_base = rd_total;
        d0 = done_cnt; e0 = err_cnt; t0 = tx_q.size();
        pulse_start(8'd20, 1'b0);
        wait_fin(d0, e0, 300, "t3_finish");
        chk("t3_reads", 64'(tx_q.size() - t0), 64'd3);
        chk("t3_rd_kind", 64'(tx_q[t0 + 2].wr), 64'd0);
        chk("t3_rd_addr", 64'(tx_q[t0 + 2].addr), 64'h3000_0000);
        chk("t3_done", 64'(done_cnt - d0), 64'd1);
        rd_pat_len = 0;

        // Pointer overflow: NOP at 254 needs word 256.
        mem[254] = 32'h0; mem[255] = 32'h0;
        d0 = done_cnt; e0 = err_cnt; f0 = fetch_q.size(); t0 = tx_q.size();
        pulse_start(8'd254, 1'b0);
        wait_fin(d0, e0, 200, "t4_finish");
        chk("t4_fetch_n", 64'(fetch_q.size() - f0), 64'd2);
        chk("t4_fetch0", 64'(fetch_q[f0]), 64'd254);
        chk("t4_fetch1", 64'(fetch_q[f0 + 1]), 64'd255);
        chk("t4_error", 64'(err_cnt - e0), 64'd1);
        chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t4_err_code", 64'(err_code), 64'd2);
        chk("t4_no_tx", 64'(tx_q.size() - t0), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);

        // POLL that never matches (read data always 0).
        mem[30] = 32'h0001_0007; mem[31] = 32'h3000_0040; mem[32] = 32'h0000_0001;
        rd_base = rd_total;
        d0 = done_cnt; e0 = err_cnt; t0 = tx_q.size();
        pulse_start(8'd30, 1'b0);
`ifdef GPE_POLL_TIMEOUT_EN
        wait_fin(d0, e0, 500, "t5_finish");
        chk("t5_reads", 64'(tx_q.size() - t0), 64'd15);
        chk("t5_error", 64'(err_cnt - e0), 64'd1);
        chk("t5_err_code", 64'(err_code), 64'd3);
`else
        for (int i = 0; i < 1000 && (tx_q.size() - t0) < 100; i++) @(negedge clk);
        chk("t5_reads_100", 64'((tx_q.size() - t0) >= 100), 64'd1);
        chk("t5_still_busy", 64'(busy), 64'd1);
        chk("t5_no_end", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_fin(d0, e0, 50, "t5_abort_finish");
        chk("t5_done", 64'(done_cnt - d0), 64'd1);
        chk("t5_no_err", 64'(err_cnt - e0), 64'd0);
        chk("t5_err_code", 64'(err_code), 64'd0);
        chk("t5_stable", 64'(stable_err), 64'd0);
`endif

        // Reserved W0 bits set: bad opcode, no bus activity.
        mem[40] = 32'h0000_0008; mem[41] = 32'h5000_0000; mem[42] = 32'h1;
        d0 = done_cnt; e0 = err_cnt; t0 = tx_q.size();
        pulse_start(8'd40, 1'b0);
        wait_fin(d0, e0, 200, "t6_finish");
        chk("t6_error", 64'(err_cnt - e0), 64'd1);
        chk("t6_err_code", 64'(err_code), 64'd1);
        chk("t6_no_tx", 64'(tx_q.size() - t0), 64'd0);

        // start and abort together: abort dropped, both commands run.
        mem[50] = 32'h0; mem[51] = 32'h0; mem[52] = 32'h0;
        mem[53] = 32'h0000_0005; mem[54] = 32'h4000_0000; mem[55] = 32'h0000_00A5;
        d0 = done_cnt; e0 = err_cnt; t0 = tx_q.size();
        pulse_start(8'd50, 1'b1);
        wait_fin(d0, e0, 300, "t7_finish");
        chk("t7_tx_n", 64'(tx_q.size() - t0), 64'd1);
        chk("t7_tx_data", 64'(tx_q[t0].dat), 64'h0000_00A5);
        chk("t7_err_code_clr", 64'(err_code), 64'd0);

        // Async reset while a WRITE waits for ready.
        mem[60] = 32'h0000_0005; mem[61] = 32'h6000_0000; mem[62] = 32'h0BAD_F00D;
        hold_ready = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        pulse_start(8'd60, 1'b0);
        for (int i = 0; i < 50 && !bus.mst_o_valid; i++) @(negedge clk);
        chk("t8_valid_seen", 64'(bus.mst_o_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t8_valid_rst", 64'(bus.mst_o_valid), 64'd0);
        chk("t8_busy_rst", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("t8_no_pulse", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
        chk("t8_idle_valid", 64'(bus.mst_o_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
